// File: rtl/pipe_cpu_pkg.sv
// Shared types and widths for the pipelined CPU data-memory path.
// Contents: state_e (responder FSM states), DATA_W (data bus width),
// CNT_W (latency counter width).
package pipe_cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : pipe_cpu_pkg

// File: rtl/dm_latency_counter.sv
// Down-counter that times the access latency of the data-memory responder.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset
//   load_i           load load_val_i (takes priority over dec_i)
//   load_val_i       value to load
//   dec_i            decrement by one; saturates at zero
//   zero_c           combinational flag, count == 0
module dm_latency_counter
    import pipe_cpu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load / decrement register; never wraps below zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule : dm_latency_counter

// File: rtl/data_mem_responder.sv
// Handshaked, fixed-latency data-memory target for the CPU MEM stage.
// Serves one load/store at a time out of a 2**ADDR_W x 32-bit word array.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o    request handshake
//   req_we_i                     1 = store, 0 = load
//   req_addr_i                   byte address, word index in [ADDR_W+1:2]
//   req_wdata_i                  store data
//   resp_valid_o / resp_ready_i  response handshake
//   resp_rdata_o                 load data (0 for stores and errors)
//   resp_err_o                   misaligned-access flag
//   busy_o                       an access is outstanding
// Optional feature: define DATA_MEM_ALIGN_CHECK_EN to reject requests with
// req_addr_i[1:0] != 0 (no write, rdata 0, resp_err_o 1). Without it the low
// address bits are ignored and resp_err_o is constant 0.
module data_mem_responder
    import pipe_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              busy_o
);

    localparam int unsigned      DEPTH    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_e state_q;
    state_e state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic accept_c;
    logic commit_c;
    logic handshake_c;
    logic cnt_zero_c;
    logic misalign_c;

    assign accept_c    = (state_q == IDLE) && req_valid_i;
    assign commit_c    = (state_q == WAIT) && cnt_zero_c;
    assign handshake_c = (state_q == RESP) && resp_ready_i;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic [1:0] low_q;

    // Byte offset of the accepted request, kept for the alignment check.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            low_q <= 2'b00;
        end else if (accept_c) begin
            low_q <= req_addr_i[1:0];
        end
    end

    assign misalign_c = (low_q != 2'b00);

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[31:ADDR_W+2];
`else
    assign misalign_c = 1'b0;

    // Upper bits alias and the byte offset is irrelevant in this build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[31:ADDR_W+2], req_addr_i[1:0]};
`endif

    // Latency timer: loaded on accept, counts down while waiting.
    dm_latency_counter u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept_c),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == WAIT),
        .zero_c     (cnt_zero_c)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)    state_d = WAIT;
            WAIT:    if (commit_c)    state_d = RESP;
            RESP:    if (handshake_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        req_ready_o  = 1'b0;
        busy_o       = 1'b1;
        resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            RESP:    resp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Request capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            we_q    <= req_we_i;
            idx_q   <= req_addr_i[ADDR_W+1:2];
            wdata_q <= req_wdata_i;
        end
    end

    // Word array; reset clears every word so an uncommitted store is lost.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_c && we_q && !misalign_c) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Response payload: captured at commit, held through RESP, cleared after.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit_c) begin
            rdata_q <= (we_q || misalign_c) ? '0 : mem[idx_q];
            err_q   <= misalign_c;
        end else if (handshake_c) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a
// randomized load/store stream compared against a word-array model.
module tb_data_mem_responder;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned LAT    = 2;
    localparam int unsigned WORDS  = 2 ** ADDR_W;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main instance (LATENCY = 2).
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, busy;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    // Second instance (LATENCY = 1) for the held-request spacing test.
    logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1, busy1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .busy_o(busy)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
        .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
        .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1), .busy_o(busy1)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [31:0] model_mem [WORDS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(WORDS); i++) model_mem[i] = 32'h0;
    endtask

    // One full request/response transaction with `stall` cycles of backpressure.
    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int stall, input string tag);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          idx;
        int          k;
        idx = int'((addr >> 2) % WORDS);
        if (ALIGN && (addr % 4 != 0)) begin
            exp_rdata = 32'h0; exp_err = 1'b1;
        end else if (we) begin
            exp_rdata = 32'h0; exp_err = 1'b0;
        end else begin
            exp_rdata = model_mem[idx]; exp_err = 1'b0;
        end

        @(negedge clk);
        check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        resp_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".busy_wait"}, 32'(busy), 32'd1);
        check({tag, ".ready_wait"}, 32'(req_ready), 32'd0);

        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, ".latency"}, 32'(k), 32'(LAT));
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(resp_err), 32'(exp_err));

        for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            check({tag, ".valid_held"}, 32'(resp_valid), 32'd1);
            check({tag, ".rdata_held"}, resp_rdata, exp_rdata);
            check({tag, ".ready_held"}, 32'(req_ready), 32'd0);
            check({tag, ".busy_held"}, 32'(busy), 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".valid_clr"}, 32'(resp_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);

        if (we && !exp_err) model_mem[idx] = wdata;
    endtask

    initial begin
        int          acc_cycles[$];
        logic [31:0] r_addr, r_data, r_rand;

        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
        req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; resp_ready1 = 1;
        model_clear();
        #2;
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic store/load, backpressure, aliasing.
        transact(1'b1, 32'h10, 32'hDEADBEEF, 0, "st10");
        transact(1'b0, 32'h10, 32'h0, 0, "ld10");
        transact(1'b0, 32'h10, 32'h0, 5, "bp10");
        transact(1'b1, 32'h204, 32'h5A, 0, "st204");
        transact(1'b0, 32'h004, 32'h0, 1, "ld004");
        transact(1'b0, 32'h3, 32'h0, 0, "ld003");
`ifdef DATA_MEM_ALIGN_CHECK_EN
        transact(1'b1, 32'h13, 32'h77, 0, "st13_mis");
        transact(1'b0, 32'h10, 32'h0, 0, "ld10_after_mis");
`endif

        // Reset during WAIT of a store: store is lost, array cleared.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(resp_valid), 32'd0);
        check("midrst.ready", 32'(req_ready), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.rdata", resp_rdata, 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        transact(1'b0, 32'h8, 32'h0, 0, "ld8_after_rst");
        transact(1'b0, 32'h10, 32'h0, 0, "ld10_after_rst");

        // Randomized stream over a small address window so loads hit stores.
        for (int n = 0; n < 40; n++) begin
            r_rand = $urandom;
            r_addr = (r_rand & 32'hFFFF_FE00) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) == 0) r_addr = r_addr | 32'($urandom_range(1, 3));
            r_data = $urandom;
            transact(1'($urandom_range(0, 1)), r_addr, r_data, int'($urandom_range(0, 3)), "rnd");
        end

        // LATENCY=1 instance with a held load request and resp_ready tied high.
        @(negedge clk);
        req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 32'h20;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (resp_valid1) check("held.no_accept_in_resp", 32'(req_ready1), 32'd0);
            if (req_ready1) acc_cycles.push_back(cyc);
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        check("held.accept_count", 32'(acc_cycles.size()), 32'd4);
        foreach (acc_cycles[i]) check("held.accept_cycle", 32'(acc_cycles[i]), 32'(3 * i));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_data_mem_responder

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Handshaked, multi-cycle data-memory target. It answers the load/store requests issued by the pipelined CPU's MEM stage.
- Replaces the zero-latency data memory with a configurable-latency word array.
- Exposes busy_o so the CPU can stall its pipeline while an access is outstanding.
- Serves one request at a time; no request queueing.

Parameters:
- ADDR_W, 7: word-index width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2: cycles from request accept to response valid; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address; bits [ADDR_W+1:2] select the word.
- req_wdata_i  in  32  store data.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  CPU consumes the response.
- resp_rdata_o  out  32  load data; 0 for stores.
- resp_err_o  out  1  error flag; only driven when ALIGN_CHECK_EN is defined, otherwise tied 0.
- busy_o  out  1  request outstanding (state != IDLE).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State returns to IDLE from any state.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, busy_o=0, req_ready_o=1 once in IDLE.
  - All array words are cleared to 0.
  - A store not yet committed is lost.
- IDLE:
  - req_ready_o=1.
  - On accept (req_valid_i & req_ready_o at a rising edge): latch we, word index req_addr_i[ADDR_W+1:2], wdata and low address bits.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready_o=0, busy_o=1.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, commit the access and go to RESP:
    - store: write the array word; resp_rdata_o=0.
    - load: resp_rdata_o = array word.
- RESP:
  - resp_valid_o=1; resp_rdata_o and resp_err_o are held stable until the handshake.
  - On resp_valid_o & resp_ready_i: go to IDLE and clear resp_valid_o.
  - No new request is accepted in the same cycle; minimum spacing between accepts is LATENCY+2 cycles.
- Timing: resp_valid_o rises exactly LATENCY rising edges after the accept edge.
- Address handling:
  - Address bits above ADDR_W+1 are ignored, so addresses alias modulo 2**(ADDR_W+2) bytes.
  - Without ALIGN_CHECK_EN, bits [1:0] are ignored.
- Arithmetic: the counter is 4 bits wide. No other arithmetic.
- Held inputs: req_valid_i held high through RESP does not re-accept until the block is back in IDLE; the held request is then accepted on the next edge.
- Read-after-write: a load to an address issued after a store response reads the new data.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- When defined:
  - A request with req_addr_i[1:0] != 0 still takes the full LATENCY.
  - It performs no array write and returns resp_rdata_o=0 with resp_err_o=1.
  - resp_err_o is 0 for aligned requests.
- When undefined: resp_err_o is constant 0 and bits [1:0] are ignored.

Decomposition:
- Shared package pipe_cpu_pkg holds:
  - the state enum (IDLE, WAIT, RESP), 2-bit encoding;
  - the data width constant 32;
  - the latency counter width constant 4.
- One sub-module, dm_latency_counter: load / decrement / zero-flag, with asynchronous active-low reset.

Test Plan:
- Reset, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> load response rdata=0xDEADBEEF; store response rdata=0; each resp_valid_o rises 2 edges after its accept.
- Backpressure: load issued with resp_ready_i=0 for 5 cycles -> resp_valid_o=1 and rdata held stable all 5 cycles; req_ready_o=0 and busy_o=1 throughout.
- Aliasing, ADDR_W=7: store 0x5A to 0x204, load 0x004 -> 0x5A.
- Reset mid-operation: assert rst_i=0 during WAIT of a store of 0x1 to 0x8 -> outputs at reset values immediately; a later load of 0x8 returns 0.
- LATENCY=1 with req_valid_i held high: accepts occur every 3 cycles with resp_ready_i=1 tied; no duplicate accept in RESP.
- DATA_MEM_ALIGN_CHECK_EN defined: store 0x77 to 0x13 -> resp_err_o=1; a later load of 0x10 returns the prior contents unchanged.
